map_tile_arbiter: RTL and testbench
===================================

MAP_TILE_ARBITER -- requirements
Module: map_tile_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2, cycles from address presentation to valid map_RAM port-B q (range 1-3).
REQ-002 Parameter NREQ, default 3, number of requesters: index 0 = pacman, 1 = ghost1, 2 = ghost2.
REQ-003 CLOCK_50  in  1  sole clock; all state on the rising edge.
REQ-004 reset  in  1  asynchronous assert, active-low; 0 = in reset.
REQ-005 req  in  NREQ  per-requester tile-write request; level, held until ack.
REQ-006 req_row  in  NREQ x 5  target map row (0-29).
REQ-007 req_col  in  NREQ x 6  target map column (0-39).
REQ-008 req_tile  in  NREQ x 4  new tile code.
REQ-009 ack  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 err  out  1  valid with ack; 1 = coordinate out of range, no write done.
REQ-011 old_tile  out  4  previous tile at the target; valid with ack.
REQ-012 busy  out  1  high from grant until the ack cycle inclusive.
REQ-013 ram_addr  out  5  map_RAM port-B address, read and write.
REQ-014 ram_q  in  160  map_RAM port-B read data.
REQ-015 ram_wren  out  1  map_RAM port-B write enable.
REQ-016 ram_wdata  out  160  map_RAM port-B write data.

Function
REQ-017 FSM states: IDLE, READ, WRITE, ACK.
REQ-018 IDLE: when any req is high, grant one requester by round-robin, latch its row/col/tile, and raise busy on the next edge.
REQ-019 Round-robin: search starts at the requester after the last acked one; after reset the search order is 0,1,2.
REQ-020 Range check at grant: row>29 or col>39 -> go directly to ACK with err=1, never assert ram_wren, and return old_tile=0.
REQ-021 READ: drive ram_addr=row for RD_LAT cycles using a down-counter, then go to WRITE.
REQ-022 WRITE: assert ram_wren for exactly one cycle; ram_wdata = ram_q with bits [156-4*col +: 4] replaced by tile; all other bits pass through unchanged.
REQ-023 old_tile is captured from ram_q[156-4*col +: 4] in the WRITE cycle.
REQ-024 ACK: pulse ack[granted] for one cycle, update the round-robin pointer, deassert busy, and return to IDLE.
REQ-025 Grant-to-ack latency is RD_LAT+2 cycles (RD_LAT=2 -> 4 cycles); an out-of-range grant acks in 1 cycle.
REQ-026 Fields are latched at grant: input changes or req drop after grant do not alter the operation, and it still completes.
REQ-027 Requests arriving while busy wait; no request is ever lost while req is held.
REQ-028 Same-cycle requests from 0 and 2 with pointer at 0: 0 is served first, then 2 immediately on return to IDLE.
REQ-029 A requester keeping req high after its ack is re-arbitrated fairly; it is not served twice while others wait.
REQ-030 ram_wren is never high outside WRITE; at most one write per transaction.
REQ-031 ram_addr holds the latched row from READ through WRITE and is 0 in IDLE.

Reset
REQ-032 While reset=0: state=IDLE, ack=0, err=0, old_tile=0, busy=0, ram_addr=0, ram_wren=0, ram_wdata=0, and the round-robin pointer selects requester 0 first.
REQ-033 Reset asserted mid-transaction deasserts ram_wren immediately (asynchronously); no partial write and no ack are produced.

Structure
REQ-034 Shared package map_pkg holds MAP_COLS=40, MAP_ROWS=30, TILE_W=4, ROW_W=160, and the tile-code enum; both this block and map_RAM_writer use it.
REQ-035 The round-robin grant logic is one sub-module, rr_arbiter, parameterized by NREQ and returning a one-hot grant plus a pointer update.

Verification
REQ-036 Single write: RAM row 5 = all 0x1, req[0] with (5,0,0x3) -> ram_wren once with addr 5 and bits[159:156]=0x3, rest unchanged; old_tile=0x1; ack[0] 4 cycles after grant.
REQ-037 Column 39 boundary: req[1] with (0,39,0xA) -> only bits[3:0] change; (0,40,x) -> err=1 with ack, no ram_wren.
REQ-038 Contention: req=3'b111 held -> acks in order 0,1,2,0,... with no requester served twice in a row while others wait.
REQ-039 Stability: change req_tile and drop req[2] one cycle after grant -> the write uses the originally latched tile and ack[2] still pulses.
REQ-040 Reset in READ with RD_LAT=2 -> no ram_wren and no ack; after release, a fresh req[1] is served first with the pointer at 0.

Source files
------------

// File: rtl/map_pkg.sv
// Shared map geometry, tile codes and arbiter state encoding used by the
// map tile arbiter and the map_RAM writer.
package map_pkg;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int TILE_W   = 4;
    localparam int ROW_W    = 160;

    typedef enum logic [3:0] {
        TILE_EMPTY = 4'h0,
        TILE_WALL  = 4'h1,
        TILE_DOT   = 4'h2,
        TILE_POWER = 4'h3,
        TILE_DOOR  = 4'h4
    } tile_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // Column 0 sits in the most significant nibble of a map row.
    function automatic logic [7:0] tile_lsb(input logic [5:0] col);
        return 8'(ROW_W - TILE_W - TILE_W * int'(col));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches from i_ptr upward (wrapping)
// and returns the first requester as one-hot plus the pointer to use next.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_grant_idx,
    output logic [PW-1:0]   o_next_ptr,
    output logic            o_any
);

    always_comb begin
        logic [PW-1:0] w_j;
        o_grant     = '0;
        o_grant_idx = '0;
        o_next_ptr  = i_ptr;
        o_any       = 1'b0;
        w_j         = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_j]) begin
                o_any       = 1'b1;
                o_grant_idx = w_j;
                o_grant     = NREQ'(1) << w_j;
                o_next_ptr  = (w_j == PW'(NREQ - 1)) ? '0 : w_j + PW'(1);
            end
        end
    end

endmodule

// File: rtl/map_tile_arbiter.sv
// Arbitrates tile-write requests from pacman and the ghosts onto map_RAM
// port B as a read-modify-write of one 160-bit row per transaction.
module map_tile_arbiter
    import map_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int NREQ   = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    // Handshake: req[i] is a level held with stable fields until ack[i]
    // pulses for one cycle; err/old_tile are valid only in that ack cycle.
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][4:0]  req_row,
    input  logic [NREQ-1:0][5:0]  req_col,
    input  logic [NREQ-1:0][3:0]  req_tile,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [3:0]            old_tile,
    output logic                  busy,
    output logic [4:0]            ram_addr,
    input  logic [ROW_W-1:0]      ram_q,
    output logic                  ram_wren,
    output logic [ROW_W-1:0]      ram_wdata,
    output logic [1:0]            dbg_state
);

    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 2;

    arb_state_t      r_state, w_next;
    logic [PW-1:0]   r_ptr, r_next_ptr, w_gidx, w_next_ptr;
    logic [NREQ-1:0] r_grant, w_grant;
    logic            w_any, w_oor, r_err;
    logic [4:0]      r_row, w_sel_row;
    logic [5:0]      r_col, w_sel_col;
    logic [3:0]      r_tile, r_old, w_sel_tile;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]      w_lsb;
    logic [ROW_W-1:0] w_mask;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_next_ptr  (w_next_ptr),
        .o_any       (w_any)
    );

    assign w_sel_row  = req_row[w_gidx];
    assign w_sel_col  = req_col[w_gidx];
    assign w_sel_tile = req_tile[w_gidx];
    assign w_oor      = (w_sel_row > 5'(MAP_ROWS - 1)) || (w_sel_col > 6'(MAP_COLS - 1));
    assign w_lsb      = tile_lsb(r_col);
    assign w_mask     = ROW_W'({TILE_W{1'b1}}) << w_lsb;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ack       = '0;
        err       = 1'b0;
        old_tile  = '0;
        busy      = 1'b0;
        ram_addr  = '0;
        ram_wren  = 1'b0;
        ram_wdata = '0;
        dbg_state = r_state;
        case (r_state)
            IDLE: if (w_any) w_next = w_oor ? ACK : READ;
            READ: begin
                busy     = 1'b1;
                ram_addr = r_row;
                if (r_cnt == '0) w_next = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                ram_addr  = r_row;
                ram_wren  = 1'b1;
                ram_wdata = (ram_q & ~w_mask) | (ROW_W'(r_tile) << w_lsb);
                w_next    = ACK;
            end
            ACK: begin
                busy     = 1'b1;
                ack      = r_grant;
                err      = r_err;
                old_tile = r_old;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Fields are captured at grant so requester changes mid-flight are ignored.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_ptr      <= '0;
            r_next_ptr <= '0;
            r_grant    <= '0;
            r_err      <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_tile     <= '0;
            r_old      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant    <= w_grant;
                    r_next_ptr <= w_next_ptr;
                    r_err      <= w_oor;
                    r_row      <= w_sel_row;
                    r_col      <= w_sel_col;
                    r_tile     <= w_sel_tile;
                    r_old      <= '0;
                    r_cnt      <= CNT_W'(RD_LAT - 1);
                end
                READ:  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                WRITE: r_old <= ram_q[w_lsb +: TILE_W];
                ACK:   r_ptr <= r_next_ptr;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// Scoreboard bench for map_tile_arbiter: directed requests push expected
// ack/write records; a negedge monitor pops and compares them.
module tb_map_tile_arbiter;

    localparam int RD_LAT = 2;
    localparam int NREQ   = 3;
    localparam logic [3:0] LAT_OK  = 4'(RD_LAT + 1);
    localparam logic [3:0] GAP_IMM = 4'(RD_LAT + 3);
    localparam logic [3:0] DC      = 4'hF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       req = '0;
    logic [2:0][4:0]  req_row = '0;
    logic [2:0][5:0]  req_col = '0;
    logic [2:0][3:0]  req_tile = '0;
    logic [2:0]       ack;
    logic             err;
    logic [3:0]       old_tile;
    logic             busy;
    logic [4:0]       ram_addr;
    logic [159:0]     ram_q;
    logic             ram_wren;
    logic [159:0]     ram_wdata;
    logic [1:0]       dbg_state;

    logic [159:0]     mem [32];
    logic [159:0]     pipe [RD_LAT];

    // {ack[2:0], err, old[3:0], lat[3:0], gap[3:0]}; gap 0xF = don't care
    logic [15:0]      exp_q[$];
    logic [164:0]     wr_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    map_tile_arbiter #(.RD_LAT(RD_LAT), .NREQ(NREQ)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .req      (req),
        .req_row  (req_row),
        .req_col  (req_col),
        .req_tile (req_tile),
        .ack      (ack),
        .err      (err),
        .old_tile (old_tile),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .ram_wren (ram_wren),
        .ram_wdata(ram_wdata),
        .dbg_state(dbg_state)
    );

    // map_RAM port-B model with RD_LAT registered read stages
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] a, input logic e, input logic [3:0] o,
                            input logic [3:0] lat, input logic [3:0] gap);
        exp_q.push_back({a, e, o, lat, gap});
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [159:0] data);
        wr_q.push_back({addr, data});
    endtask

    task automatic set_req(input int i, input logic [4:0] row, input logic [5:0] col, input logic [3:0] tile);
        req_row[i]  = row;
        req_col[i]  = col;
        req_tile[i] = tile;
        req[i]      = 1'b1;
    endtask

    // Waits for the expected number of acks on the masked requesters,
    // dropping each requester once it has been served 'rounds' times.
    task automatic serve(input logic [2:0] mask, input int rounds);
        int cnt [3];
        int total;
        int need;
        cnt   = '{0, 0, 0};
        total = 0;
        need  = $countones(mask) * rounds;
        for (int t = 0; t < 400 && total < need; t++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (mask[b] && ack[b]) begin
                    cnt[b]++;
                    total++;
                    if (cnt[b] == rounds) req[b] = 1'b0;
                end
            end
        end
        if (total < need) chk("serve_timeout", 160'(total), 160'(need));
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!busy) chk("busy_timeout", 160'(busy), 160'(1));
    endtask

    // Monitor: pops the scoreboard whenever an ack or a RAM write appears.
    initial begin
        int busy_rise;
        int last_ack;
        logic prev_busy;
        logic [15:0] e;
        logic [164:0] w;
        busy_rise = 0;
        last_ack  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) busy_rise = cyc;
            prev_busy = busy;
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 160'(ack), 160'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_vec", 160'(ack), 160'(e[15:13]));
                    chk("ack_err", 160'(err), 160'(e[12]));
                    chk("old_tile", 160'(old_tile), 160'(e[11:8]));
                    chk("grant_to_ack", 160'(cyc - busy_rise), 160'(e[7:4]));
                    if (e[3:0] != DC) chk("ack_gap", 160'(cyc - last_ack), 160'(e[3:0]));
                end
                last_ack = cyc;
            end
            if (ram_wren) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wren", 160'(ram_addr), 160'(0));
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 160'(ram_addr), 160'(w[164:160]));
                    chk("wr_data", ram_wdata, w[159:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) mem[r] = '0;
        mem[5]  = {40{4'h1}};
        mem[0]  = {40{4'h2}};
        mem[10] = {40{4'h7}};
        mem[11] = {40{4'h8}};
        mem[12] = {40{4'h9}};
        mem[20] = {40{4'hC}};
        mem[22] = {40{4'hE}};
        mem[23] = {40{4'h4}};
        mem[24] = {40{4'h5}};
        mem[25] = {40{4'h3}};

        repeat (3) @(negedge clk);
        chk("rst_ack", 160'(ack), 160'(0));
        chk("rst_err", 160'(err), 160'(0));
        chk("rst_old", 160'(old_tile), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_addr", 160'(ram_addr), 160'(0));
        chk("rst_wren", 160'(ram_wren), 160'(0));
        chk("rst_wdata", ram_wdata, 160'(0));
        chk("rst_state", 160'(dbg_state), 160'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write at column 0
        push_exp(3'b001, 1'b0, 4'h1, LAT_OK, DC);
        push_wr(5'd5, {4'h3, {39{4'h1}}});
        set_req(0, 5'd5, 6'd0, 4'h3);
        serve(3'b001, 1);

        // column 39 boundary, then column 40 and row 30 rejected
        @(negedge clk);
        push_exp(3'b010, 1'b0, 4'h2, LAT_OK, DC);
        push_wr(5'd0, {{39{4'h2}}, 4'hA});
        set_req(1, 5'd0, 6'd39, 4'hA);
        serve(3'b010, 1);
        @(negedge clk);
        push_exp(3'b010, 1'b1, 4'h0, 4'd0, DC);
        set_req(1, 5'd0, 6'd40, 4'h5);
        serve(3'b010, 1);
        @(negedge clk);
        push_exp(3'b100, 1'b1, 4'h0, 4'd0, DC);
        set_req(2, 5'd30, 6'd0, 4'h1);
        serve(3'b100, 1);

        // three-way contention held for two rounds, pointer at 0
        @(negedge clk);
        push_exp(3'b001, 1'b0, 4'h7, LAT_OK, DC);
        push_exp(3'b010, 1'b0, 4'h8, LAT_OK, GAP_IMM);
        push_exp(3'b100, 1'b0, 4'h9, LAT_OK, GAP_IMM);
        push_exp(3'b001, 1'b0, 4'h4, LAT_OK, GAP_IMM);
        push_exp(3'b010, 1'b0, 4'h5, LAT_OK, GAP_IMM);
        push_exp(3'b100, 1'b0, 4'h6, LAT_OK, GAP_IMM);
        for (int r = 0; r < 2; r++) begin
            push_wr(5'd10, {4'h7, 4'h4, {38{4'h7}}});
            push_wr(5'd11, {{2{4'h8}}, 4'h5, {37{4'h8}}});
            push_wr(5'd12, {{3{4'h9}}, 4'h6, {36{4'h9}}});
        end
        set_req(0, 5'd10, 6'd1, 4'h4);
        set_req(1, 5'd11, 6'd2, 4'h5);
        set_req(2, 5'd12, 6'd3, 4'h6);
        serve(3'b111, 2);

        // fields latched at grant; req dropped one cycle after grant
        @(negedge clk);
        push_exp(3'b100, 1'b0, 4'hC, LAT_OK, DC);
        push_wr(5'd20, {4'hB, {39{4'hC}}});
        set_req(2, 5'd20, 6'd0, 4'hB);
        wait_busy();
        req_tile[2] = 4'hF;
        req_row[2]  = 5'd3;
        req[2]      = 1'b0;
        serve(3'b100, 1);

        // simultaneous 0 and 2: 0 first, 2 granted right after
        @(negedge clk);
        push_exp(3'b001, 1'b0, 4'h0, LAT_OK, DC);
        push_exp(3'b100, 1'b0, 4'hE, LAT_OK, GAP_IMM);
        push_wr(5'd21, {{5{4'h0}}, 4'h1, {34{4'h0}}});
        push_wr(5'd22, {{38{4'hE}}, 4'h2, 4'hE});
        set_req(0, 5'd21, 6'd5, 4'h1);
        set_req(2, 5'd22, 6'd38, 4'h2);
        serve(3'b101, 1);

        // leave the pointer at 2 before the reset test
        @(negedge clk);
        push_exp(3'b010, 1'b0, 4'h3, LAT_OK, DC);
        push_wr(5'd25, {{10{4'h3}}, 4'h9, {29{4'h3}}});
        set_req(1, 5'd25, 6'd10, 4'h9);
        serve(3'b010, 1);

        // reset during READ: no write, no ack, pointer back to 0
        @(negedge clk);
        set_req(0, 5'd23, 6'd0, 4'h5);
        wait_busy();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wren", 160'(ram_wren), 160'(0));
        chk("midrst_ack", 160'(ack), 160'(0));
        chk("midrst_busy", 160'(busy), 160'(0));
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_row23", mem[23], {40{4'h4}});

        push_exp(3'b010, 1'b0, 4'h5, LAT_OK, DC);
        push_exp(3'b100, 1'b0, 4'h0, LAT_OK, GAP_IMM);
        push_wr(5'd24, {4'h5, 4'h3, {38{4'h5}}});
        push_wr(5'd26, {{20{4'h0}}, 4'h7, {19{4'h0}}});
        set_req(1, 5'd24, 6'd1, 4'h3);
        set_req(2, 5'd26, 6'd20, 4'h7);
        serve(3'b110, 1);

        repeat (5) @(negedge clk);
        chk("final_row5", mem[5], {4'h3, {39{4'h1}}});
        chk("final_row10", mem[10], {4'h7, 4'h4, {38{4'h7}}});
        chk("exp_q_empty", 160'(exp_q.size()), 160'(0));
        chk("wr_q_empty", 160'(wr_q.size()), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
